fmap_stream_tx: RTL and testbench

- Source end of the activation stream consumed by the sliding-window line buffers: holds one input frame in local storage and emits it row-major, one pixel per cycle, with `valid`, `last` and a trailing `flush` pulse.
- Sits in front of the first buffer stage of the network pipeline.
- A host loads the frame through a simple write port, then pulses `start`.

---
 rtl/lenet_pkg.sv | 16 +
 rtl/fmap_frame_ram.sv | 35 +++
 rtl/fmap_stream_tx.sv | 163 ++++++++++++++++
 tb/tb_fmap_stream_tx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared types and default sizes for the activation-stream blocks.
// Holds the activation word type and the frame streamer state encoding.
package lenet_pkg;

    localparam int LENET_BITWIDTH = 16;
    localparam int LENET_NFMAPS   = 1;

    typedef logic [LENET_BITWIDTH-1:0] act_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } stream_state_e;

endpackage

// File: rtl/fmap_frame_ram.sv
// Frame store: one write port, one synchronous read port, read data registered.
// Latency: 1 cycle read. Backpressure: none; rd_en low holds rd_data.
// Memory contents are not reset; only the read register is.
module fmap_frame_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 16,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fmap_stream_tx.sv
// Frame streamer: stores one frame, then emits it row-major with valid/last and a trailing flush pulse.
// Latency: pixel k two cycles after start plus k. Backpressure: optional stall (FMAP_STREAM_TX_STALL_EN) freezes the stream.
// Without FMAP_STREAM_TX_STALL_EN the stream runs one pixel per cycle unconditionally.
module fmap_stream_tx
    import lenet_pkg::*;
#(
    parameter int BITWIDTH = LENET_BITWIDTH,
    parameter int NFMAPS   = LENET_NFMAPS,
    parameter int NW       = 32,
    parameter int NH       = 32,
    parameter int AW       = 10
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [NFMAPS*BITWIDTH-1:0] wr_data,
    input  logic                       start,
`ifdef FMAP_STREAM_TX_STALL_EN
    input  logic                       stall,
`endif
    output logic [NFMAPS*BITWIDTH-1:0] output_act,
    output logic                       valid,
    output logic                       last,
    output logic                       flush,
    output logic                       busy,
    output logic                       wr_err
);

    localparam int DEPTH = NW * NH;
    localparam int WIDTH = NFMAPS * BITWIDTH;
    localparam int CW    = (NW > 1) ? $clog2(NW) : 1;
    localparam int RW    = (NH > 1) ? $clog2(NH) : 1;

    localparam logic [AW:0]   DEPTH_A = DEPTH[AW:0];
    localparam logic [CW-1:0] COL_MAX = CW'(NW - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(NH - 1);

    stream_state_e state_q, state_d;

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [AW-1:0] addr_q;
    logic          busy_q;
    logic          vld_q;
    logic          last_q;
    logic          flush_q;
    logic          wr_err_q;
    logic          rd_en;
    logic          adv;
    logic          at_end;
    logic          start_ok;
    logic          wr_ok;

`ifdef FMAP_STREAM_TX_STALL_EN
    assign adv = ~stall;
`else
    assign adv = 1'b1;
`endif

    assign at_end   = (col_q == COL_MAX) && (row_q == ROW_MAX);
    assign start_ok = (state_q == IDLE) && start && !busy_q;
    // busy_q low implies IDLE, so it alone gates host writes into the store.
    assign wr_ok    = wr_en && !busy_q && ({1'b0, wr_addr} < DEPTH_A);

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                rd_en = adv;
                if (at_end) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            flush_q <= 1'b0;
        end else if (adv) begin
            state_q <= state_d;
            vld_q   <= (state_q == STREAM);
            last_q  <= (state_q == STREAM) && at_end;
            flush_q <= (state_q == FLUSH);

            if (start_ok) begin
                busy_q <= 1'b1;
                col_q  <= '0;
                row_q  <= '0;
                addr_q <= '0;
            end else if (flush_q) begin
                busy_q <= 1'b0;
            end

            if (state_q == STREAM) begin
                if (at_end) begin
                    col_q  <= '0;
                    row_q  <= '0;
                    addr_q <= '0;
                end else begin
                    addr_q <= addr_q + 1'b1;
                    if (col_q == COL_MAX) begin
                        col_q <= '0;
                        row_q <= row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
            end
        end
    end

    // Write errors are reported regardless of stall so the host always sees them.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_en && !wr_ok;
        end
    end

    fmap_frame_ram #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH),
        .AW   (AW)
    ) u_ram (
        .clk    (clk),
        .rstn   (rstn),
        .wr_en  (wr_ok),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .rd_en  (rd_en),
        .rd_addr(addr_q),
        .rd_data(output_act)
    );

    assign valid  = vld_q & adv;
    assign last   = last_q & adv;
    assign flush  = flush_q & adv;
    assign busy   = busy_q;
    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_fmap_stream_tx.sv
// Scoreboard bench for fmap_stream_tx on a 4x3 frame: stimulus pushes expected pixels/flush/errors with
// their due cycle; a negedge monitor pops and compares whenever the DUT presents an output.
module tb_fmap_stream_tx;

    localparam int NW = 4;
    localparam int NH = 3;
    localparam int NPIX = NW * NH;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [15:0] output_act;
    logic        valid, last, flush, busy, wr_err;

    fmap_stream_tx #(
        .BITWIDTH(16), .NFMAPS(1), .NW(NW), .NH(NH), .AW(4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
`ifdef FMAP_STREAM_TX_STALL_EN
        .stall     (stall),
`endif
        .output_act(output_act),
        .valid     (valid),
        .last      (last),
        .flush     (flush),
        .busy      (busy),
        .wr_err    (wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_flush;
        logic [15:0] d;
        bit          lst;
        int          c;
    } ev_t;

    ev_t         exp_q[$];
    int          err_q[$];
    logic [15:0] mdl_mem [NPIX];
    int          cyc = 0;
    int          bsy_lo = 1;
    int          bsy_hi = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle of host activity; the model decides acceptance from the busy window it predicts.
    task automatic drive_cycle(input bit we, input logic [3:0] a, input logic [15:0] d, input bit st);
        bit  busy_now;
        ev_t e;
        wr_en = we; wr_addr = a; wr_data = d; start = st;
        busy_now = (cyc >= bsy_lo) && (cyc <= bsy_hi);
        if (we) begin
            if (busy_now || int'(a) >= NPIX) err_q.push_back(cyc + 1);
            else mdl_mem[a] = d;
        end
        if (st && !busy_now) begin
            bsy_lo = cyc + 1;
            bsy_hi = cyc + NPIX + 2;
            for (int k = 0; k < NPIX; k++) begin
                e.is_flush = 1'b0; e.d = mdl_mem[k]; e.lst = (k == NPIX - 1); e.c = cyc + 2 + k;
                exp_q.push_back(e);
            end
            e.is_flush = 1'b1; e.d = '0; e.lst = 1'b0; e.c = cyc + 2 + NPIX;
            exp_q.push_back(e);
        end
        tick();
        wr_en = 1'b0; start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b0, 4'd0, 16'd0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            ev_t e;
            chk("busy", busy, (cyc >= bsy_lo) && (cyc <= bsy_hi));
            chk("last_without_valid", last & ~valid, 0);
            if (valid || flush) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {valid, flush}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("kind_flush", flush, e.is_flush);
                    chk("out_cycle", cyc, e.c);
                    if (!e.is_flush) begin
                        chk("pixel_data", output_act, e.d);
                        chk("last", last, e.lst);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
                e = exp_q.pop_front();
                chk("missing_output_cycle", cyc, e.c - 1);
            end
            if (wr_err) begin
                if (err_q.size() == 0) chk("unexpected_wr_err", wr_err, 0);
                else chk("wr_err_cycle", cyc, err_q.pop_front());
            end else if (err_q.size() > 0 && err_q[0] <= cyc) begin
                chk("missing_wr_err", 0, 1);
                void'(err_q.pop_front());
            end
        end
    end

    initial begin
        int c0;
        for (int i = 0; i < NPIX; i++) mdl_mem[i] = 16'hxxxx;

        // Reset state
        #2;
        chk("rst_valid", valid, 0);
        chk("rst_last", last, 0);
        chk("rst_flush", flush, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_output_act", output_act, 0);
        tick(); tick();
        rstn = 1'b1;
        tick();

        // Directed frame 0x0100+i
        for (int i = 0; i < NPIX; i++) drive_cycle(1'b1, 4'(i), 16'h0100 + 16'(i), 1'b0);
        drive_cycle(1'b0, 4'd0, 16'd0, 1'b1);
        idle(18);

        // Out-of-range write in IDLE, write while busy, start re-pulsed mid-stream
        drive_cycle(1'b1, 4'd12, 16'hBEEF, 1'b0);
        c0 = cyc;
        drive_cycle(1'b0, 4'd0, 16'd0, 1'b1);
        idle(2);
        drive_cycle(1'b1, 4'd3, 16'hDEAD, 1'b0);
        idle(1);
        drive_cycle(1'b0, 4'd0, 16'd0, 1'b1);
        idle(18);
        drive_cycle(1'b0, 4'd0, 16'd0, 1'b1);
        idle(18);

        // Reset mid-stream: outputs drop without waiting for an edge
        drive_cycle(1'b0, 4'd0, 16'd0, 1'b1);
        idle(5);
        rstn = 1'b0;
        #1;
        chk("abort_valid", valid, 0);
        chk("abort_flush", flush, 0);
        chk("abort_busy", busy, 0);
        exp_q.delete();
        err_q.delete();
        bsy_lo = 1; bsy_hi = 0;
        tick(); tick();
        rstn = 1'b1;
        idle(2);
        drive_cycle(1'b0, 4'd0, 16'd0, 1'b1);
        idle(18);

        // Back-to-back: start held until the first accepted IDLE cycle
        drive_cycle(1'b0, 4'd0, 16'd0, 1'b1);
        repeat (NPIX + 3) drive_cycle(1'b0, 4'd0, 16'd0, 1'b1);
        idle(20);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            drive_cycle(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
                        16'($urandom), ($urandom_range(0, 19) == 0));
        end
        idle(20);

        chk("exp_queue_drained", exp_q.size(), 0);
        chk("err_queue_drained", err_q.size(), 0);
        if (c0 < 0) chk("unused", 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
